// File: rtl/conv_stream_feeder.sv
// Feeds the systolic convolution engine: bias + weights first, then the layer's pixels, then a flush.
// Optional build macro CONV_FEEDER_STALL_STATS_EN adds the stall_cnt output.
module conv_stream_feeder #(
    parameter int unsigned IMG_DIM    = 6,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           layer_nr_in,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  weight_we,
    output logic [DATA_WIDTH-1:0] weight_data,
    output logic                  conv_en,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic [31:0]           layer_nr,
    output logic                  busy,
    output logic                  done
`ifdef CONV_FEEDER_STALL_STATS_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int unsigned NUM_WEIGHTS = KERNEL_DIM * KERNEL_DIM + 1;
    localparam int unsigned WCNT_W      = $clog2(KERNEL_DIM * KERNEL_DIM + 2);
    localparam int unsigned FCNT_W      = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
    localparam int unsigned POOL_DIM    = (IMG_DIM - KERNEL_DIM + 1) / 2;

    localparam logic [31:0]       NPIX_L0   = 32'(IMG_DIM * IMG_DIM);
    localparam logic [31:0]       NPIX_L1   = 32'(POOL_DIM * POOL_DIM);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NUM_WEIGHTS - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(KERNEL_DIM - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic [31:0]             pcnt_q, pcnt_d;
    logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic [31:0]             layer_q, layer_d;
    logic                    weight_we_q, weight_we_d;
    logic [DATA_WIDTH-1:0]   weight_data_q, weight_data_d;
    logic                    conv_en_q, conv_en_d;
    logic [DATA_WIDTH-1:0]   pixel_q, pixel_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [31:0]             n_pix;

    // Pixel count is derived from the latched layer, so it is stable for the whole job.
    always_comb begin
        unique case (layer_q)
            32'd0:   n_pix = NPIX_L0;
            32'd1:   n_pix = NPIX_L1;
            default: n_pix = '0;
        endcase
    end

    // Ready depends on state only, so the upstream FIFO sees no combinational loop through s_valid.
    assign s_ready = (state_q == LOAD_W) || (state_q == STREAM);

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        pcnt_d        = pcnt_q;
        fcnt_d        = fcnt_q;
        layer_d       = layer_q;
        weight_we_d   = 1'b0;
        weight_data_d = weight_data_q;
        conv_en_d     = 1'b0;
        pixel_d       = pixel_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    layer_d = layer_nr_in;
                    busy_d  = 1'b1;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
                    fcnt_d  = '0;
                end
            end
            LOAD_W: begin
                if (s_valid) begin
                    weight_we_d   = 1'b1;
                    weight_data_d = s_data;
                    wcnt_d        = wcnt_q + 1'b1;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d = (n_pix == '0) ? FLUSH : STREAM;
                        fcnt_d  = '0;
                    end
                end
            end
            STREAM: begin
                if (s_valid) begin
                    conv_en_d = 1'b1;
                    pixel_d   = s_data;
                    pcnt_d    = pcnt_q + 32'd1;
                    if (pcnt_q == n_pix - 32'd1) begin
                        state_d = FLUSH;
                        fcnt_d  = '0;
                    end
                end
            end
            FLUSH: begin
                pixel_d = '0;
                if (fcnt_q == FCNT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                wcnt_d  = '0;
                pcnt_d  = '0;
                fcnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            pcnt_q        <= '0;
            fcnt_q        <= '0;
            layer_q       <= '0;
            weight_we_q   <= 1'b0;
            weight_data_q <= '0;
            conv_en_q     <= 1'b0;
            pixel_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            pcnt_q        <= pcnt_d;
            fcnt_q        <= fcnt_d;
            layer_q       <= layer_d;
            weight_we_q   <= weight_we_d;
            weight_data_q <= weight_data_d;
            conv_en_q     <= conv_en_d;
            pixel_q       <= pixel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign weight_we   = weight_we_q;
    assign weight_data = weight_data_q;
    assign conv_en     = conv_en_q;
    assign pixel_out   = pixel_q;
    assign layer_nr    = layer_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef CONV_FEEDER_STALL_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Counts ready-but-starved cycles; value survives done so software can read it afterwards.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if (s_ready && !s_valid && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
